// File: rtl/cpu_bmu_stage_pkg.sv
// Shared definitions for the bit-manipulation unit and its execute stage.
// Holds the BMU control codes plus the opcode / funct / imm12 constants
// used to decode the supported Zbb subset.
package cpu_bmu_stage_pkg;

  typedef enum logic [2:0] {
    BMU_CLZ  = 3'd0,
    BMU_CTZ  = 3'd1,
    BMU_CPOP = 3'd2,
    BMU_ANDN = 3'd3,
    BMU_ORN  = 3'd4,
    BMU_ROL  = 3'd5,
    BMU_ROR  = 3'd6
  } bmu_op_e;

  localparam logic [6:0]  OPC_OP       = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;

  localparam logic [6:0]  F7_ZBB_LOGN  = 7'b0100000;  // andn / orn
  localparam logic [6:0]  F7_ZBB_ROT   = 7'b0110000;  // rol / ror / rori (RV32)
  localparam logic [5:0]  F6_ZBB_ROTI  = 6'b011000;   // rori (RV64, 6-bit shamt)

  localparam logic [2:0]  F3_ANDN      = 3'b111;
  localparam logic [2:0]  F3_ORN       = 3'b110;
  localparam logic [2:0]  F3_ROL       = 3'b001;
  localparam logic [2:0]  F3_ROR       = 3'b101;
  localparam logic [2:0]  F3_UNARY     = 3'b001;
  localparam logic [2:0]  F3_RORI      = 3'b101;

  localparam logic [11:0] IMM12_CLZ    = 12'h600;
  localparam logic [11:0] IMM12_CTZ    = 12'h601;
  localparam logic [11:0] IMM12_CPOP   = 12'h602;

endpackage

// File: rtl/cpu_bmu.sv
// Combinational bit-manipulation unit.
//   op        : BMU control code (bmu_op_e)
//   operand_a : rs1 value
//   operand_b : rs2 value or immediate; rotates use its low log2(XLEN) bits
//   result    : operation result
module cpu_bmu
  import cpu_bmu_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]    sh;
  logic [SHW:0]      lz, tz, pc;
  logic [2*XLEN-1:0] rol_w, ror_w;

  assign sh = operand_b[SHW-1:0];

  // Rotating a doubled word: the high half of a left shift and the low half
  // of a right shift are exactly the rotated values.
  assign rol_w = {operand_a, operand_a} << sh;
  assign ror_w = {operand_a, operand_a} >> sh;

  always_comb begin
    lz = (SHW+1)'(XLEN);
    tz = (SHW+1)'(XLEN);
    pc = '0;
    // Ascending scan: the highest set bit is the last to write lz.
    for (int i = 0; i < XLEN; i++)
      if (operand_a[i]) lz = (SHW+1)'(XLEN - 1 - i);
    // Descending scan: the lowest set bit is the last to write tz.
    for (int i = XLEN - 1; i >= 0; i--)
      if (operand_a[i]) tz = (SHW+1)'(i);
    for (int i = 0; i < XLEN; i++)
      pc = pc + {{SHW{1'b0}}, operand_a[i]};
  end

  always_comb begin
    result = '0;
    case (bmu_op_e'(op))
      BMU_CLZ:  result = {{(XLEN-SHW-1){1'b0}}, lz};
      BMU_CTZ:  result = {{(XLEN-SHW-1){1'b0}}, tz};
      BMU_CPOP: result = {{(XLEN-SHW-1){1'b0}}, pc};
      BMU_ANDN: result = operand_a & ~operand_b;
      BMU_ORN:  result = operand_a | ~operand_b;
      BMU_ROL:  result = rol_w[2*XLEN-1:XLEN];
      BMU_ROR:  result = ror_w[XLEN-1:0];
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_bmu_stage.sv
// Execute-stage wrapper around cpu_bmu: decodes the Zbb subset, registers
// the decoded operation (S1), evaluates cpu_bmu on S1 and registers the
// result (S2). Two-deep, one instruction per cycle at full throughput.
//   clk, reset        : clock, synchronous active-high reset
//   flush             : kill all in-flight entries (and any same-cycle accept)
//   in_valid/in_ready : upstream handshake; in_instr, in_rs1_data, in_rs2_data
//   out_valid/out_ready : writeback handshake; out_result, out_rd, out_illegal
module cpu_bmu_stage
  import cpu_bmu_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  typedef struct packed {
    bmu_op_e         op;
    logic [XLEN-1:0] opb;
    logic            ill;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr, input logic [XLEN-1:0] rs2);
    dec_t d;
    d.op  = BMU_CLZ;
    d.opb = '0;
    d.ill = 1'b1;
    if (instr[6:0] == OPC_OP) begin
      d.opb = rs2;
      if (instr[31:25] == F7_ZBB_LOGN && instr[14:12] == F3_ANDN) begin d.op = BMU_ANDN; d.ill = 1'b0; end
      if (instr[31:25] == F7_ZBB_LOGN && instr[14:12] == F3_ORN)  begin d.op = BMU_ORN;  d.ill = 1'b0; end
      if (instr[31:25] == F7_ZBB_ROT  && instr[14:12] == F3_ROL)  begin d.op = BMU_ROL;  d.ill = 1'b0; end
      if (instr[31:25] == F7_ZBB_ROT  && instr[14:12] == F3_ROR)  begin d.op = BMU_ROR;  d.ill = 1'b0; end
    end else if (instr[6:0] == OPC_OP_IMM) begin
      if (instr[14:12] == F3_UNARY) begin
        if (instr[31:20] == IMM12_CLZ)  begin d.op = BMU_CLZ;  d.ill = 1'b0; end
        if (instr[31:20] == IMM12_CTZ)  begin d.op = BMU_CTZ;  d.ill = 1'b0; end
        if (instr[31:20] == IMM12_CPOP) begin d.op = BMU_CPOP; d.ill = 1'b0; end
      end else if (instr[14:12] == F3_RORI) begin
        // RORI goes to the BMU as ROR with the shamt field as operand_b.
        if (XLEN == 64) begin
          if (instr[31:26] == F6_ZBB_ROTI) begin
            d.op = BMU_ROR; d.opb = XLEN'(instr[25:20]); d.ill = 1'b0;
          end
        end else if (instr[31:25] == F7_ZBB_ROT) begin
          d.op = BMU_ROR; d.opb = XLEN'(instr[24:20]); d.ill = 1'b0;
        end
      end
    end
    return d;
  endfunction

  dec_t            in_dec;
  logic            accept, s1_adv, s2_free;
  logic            s1_valid, s2_valid;
  dec_t            s1_dec;
  logic [XLEN-1:0] s1_opa;
  logic [4:0]      s1_rd;
  logic [XLEN-1:0] bmu_result;
  logic [XLEN-1:0] s2_result;
  logic [4:0]      s2_rd;
  logic            s2_ill;

  assign in_dec   = decode(in_instr, in_rs2_data);
  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;

  cpu_bmu #(.XLEN(XLEN)) u_bmu (
    .op        (s1_dec.op),
    .operand_a (s1_opa),
    .operand_b (s1_dec.opb),
    .result    (bmu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_dec    <= '0;
      s1_opa    <= '0;
      s1_rd     <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_rd     <= '0;
      s2_ill    <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_dec   <= in_dec;
        s1_opa   <= in_rs1_data;
        s1_rd    <= in_instr[11:7];
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      // S2 data only loads on advance, so it holds while stalled.
      if (s1_adv) begin
        s2_valid  <= 1'b1;
        s2_result <= s1_dec.ill ? '0 : bmu_result;
        s2_rd     <= s1_rd;
        s2_ill    <= s1_dec.ill;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_rd      = s2_rd;
  assign out_illegal = s2_ill;

endmodule

// File: tb/tb_cpu_bmu_stage.sv
// Scoreboard bench for cpu_bmu_stage: a reference model computes each
// accepted instruction's result; a negedge monitor predicts in_ready /
// out_valid from queue occupancy and entry age and compares outputs.
module tb_cpu_bmu_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, out_result;
  logic [4:0]      out_rd;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
    logic            ill;
    int              cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;
  bit   post_rst = 1'b0;

  cpu_bmu_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [XLEN-1:0] rotr(input logic [XLEN-1:0] a, input int s);
    logic [XLEN-1:0] r;
    r = a;
    for (int k = 0; k < s; k++) r = {r[0], r[XLEN-1:1]};
    return r;
  endfunction

  function automatic logic [XLEN-1:0] rotl(input logic [XLEN-1:0] a, input int s);
    return rotr(a, (XLEN - s) % XLEN);
  endfunction

  // Reference model straight from the instruction semantics.
  function automatic exp_t model(input logic [31:0] ins, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e;
    int n;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [11:0] imm;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; imm = ins[31:20];
    e.rd = ins[11:7]; e.ill = 1'b0; e.res = '0; e.cyc = cyc; n = 0;
    if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd7)      e.res = a & ~b;
    else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd6) e.res = a | ~b;
    else if (opc == 7'h33 && f7 == 7'h30 && f3 == 3'd1) e.res = rotl(a, int'(b % XLEN));
    else if (opc == 7'h33 && f7 == 7'h30 && f3 == 3'd5) e.res = rotr(a, int'(b % XLEN));
    else if (opc == 7'h13 && f3 == 3'd1 && imm == 12'h600) begin
      while (n < XLEN && a[XLEN-1-n] == 1'b0) n++;
      e.res = XLEN'(n);
    end else if (opc == 7'h13 && f3 == 3'd1 && imm == 12'h601) begin
      while (n < XLEN && a[n] == 1'b0) n++;
      e.res = XLEN'(n);
    end else if (opc == 7'h13 && f3 == 3'd1 && imm == 12'h602) e.res = XLEN'($countones(a));
    else if (XLEN == 32 && opc == 7'h13 && f3 == 3'd5 && f7 == 7'h30) e.res = rotr(a, int'(ins[24:20]));
    else if (XLEN == 64 && opc == 7'h13 && f3 == 3'd5 && ins[31:26] == 6'h18) e.res = rotr(a, int'(ins[25:20]));
    else e.ill = 1'b1;
    return e;
  endfunction

  // Monitor: occupancy/age model for handshake, scoreboard for data.
  always @(negedge clk) begin
    logic exp_rdy, exp_ov;
    if (reset) begin
      q.delete();
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        post_rst = 1'b0;
      end
      exp_rdy = (q.size() < 2) || out_ready;
      exp_ov  = (q.size() > 0) && (cyc - q[0].cyc >= 2);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (out_valid && q.size() > 0) begin
        chk("out_result", 64'(out_result), 64'(q[0].res));
        chk("out_rd", 64'(out_rd), 64'(q[0].rd));
        chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
      end
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back(model(in_instr, in_rs1_data, in_rs2_data));
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int t;
    t = 0;
    in_valid = 1'b1; in_instr = ins; in_rs1_data = a; in_rs2_data = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin t++; @(negedge clk); end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for instr %08h", ins);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'($urandom), 5'($urandom), f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'($urandom), f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0] rd;
    logic [31:0] i;
    rd = 5'($urandom);
    case ($urandom_range(0, 11))
      0:  i = r_type(7'h20, 3'd7, rd);
      1:  i = r_type(7'h20, 3'd6, rd);
      2:  i = r_type(7'h30, 3'd1, rd);
      3:  i = r_type(7'h30, 3'd5, rd);
      4:  i = i_type(12'h600, 3'd1, rd);
      5:  i = i_type(12'h601, 3'd1, rd);
      6:  i = i_type(12'h602, 3'd1, rd);
      7:  i = i_type({7'h30, 5'($urandom)}, 3'd5, rd);
      8:  i = r_type(7'h00, 3'd0, rd);                                 // ADD
      9:  i = {12'h600, 5'($urandom), 3'd1, rd, 7'h1b};                // CLZW
      10: i = ($urandom % 2) ? i_type(12'h603, 3'd1, rd)
                             : i_type({7'h31, 5'($urandom)}, 3'd5, rd); // near misses
      default: i = $urandom;
    endcase
    return i;
  endfunction

  function automatic logic [XLEN-1:0] gen_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return XLEN'(1) << $urandom_range(0, XLEN-1);
      3: return ~(XLEN'(1) << $urandom_range(0, XLEN-1));
      default: return XLEN'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_rs1_data = '0; in_rs2_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // ANDN rd=5
    issue({7'h20, 5'd2, 5'd1, 3'd7, 5'd5, 7'h33}, 32'hFF00FF00, 32'h00FF00FF);
    idle(3);

    // CLZ / CTZ / CPOP back to back
    issue({12'h600, 5'd1, 3'd1, 5'd3, 7'h13}, 32'h6, 32'h0);
    issue({12'h601, 5'd1, 3'd1, 5'd4, 7'h13}, 32'h0F000020, 32'h0);
    issue({12'h602, 5'd1, 3'd1, 5'd6, 7'h13}, 32'hF0F0F0F0, 32'h0);
    idle(3);

    // RORI shamt=1, rs2 ignored
    issue({7'h30, 5'd1, 5'd2, 3'd5, 5'd9, 7'h13}, 32'h1, 32'hFFFF);
    idle(3);

    // Backpressure: three instructions against a stalled writeback
    out_ready = 1'b0;
    fork
      begin
        issue(r_type(7'h20, 3'd6, 5'd10), gen_opnd(), gen_opnd());
        issue(r_type(7'h30, 3'd1, 5'd11), gen_opnd(), gen_opnd());
        issue(r_type(7'h30, 3'd5, 5'd12), gen_opnd(), gen_opnd());
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(4);

    // Illegal ADD rd=7
    issue(32'h000003B3, 32'h1234, 32'h5678);
    idle(3);

    // Flush with two in flight plus a same-cycle accept
    issue(r_type(7'h20, 3'd7, 5'd13), gen_opnd(), gen_opnd());
    issue(r_type(7'h20, 3'd7, 5'd14), gen_opnd(), gen_opnd());
    in_valid = 1'b1; in_instr = i_type(12'h602, 3'd1, 5'd15); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle(4);

    // Reset mid-stream
    issue(i_type(12'h600, 3'd1, 5'd16), gen_opnd(), gen_opnd());
    issue(i_type(12'h601, 3'd1, 5'd17), gen_opnd(), gen_opnd());
    in_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(4);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      in_valid    = ($urandom % 4) != 0;
      out_ready   = ($urandom % 4) != 0;
      flush       = ($urandom % 50) == 0;
      in_instr    = gen_instr();
      in_rs1_data = gen_opnd();
      in_rs2_data = gen_opnd();
      @(posedge clk); #1;
    end
    flush = 1'b0; out_ready = 1'b1;
    idle(6);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
